demux_stream_router: RTL and testbench

//  Registered, parametrised 1:N stream de-multiplexer with valid/ready handshake per channel.

---
 rtl/demux_stream_router.sv | 109 ++++++++++
 tb/tb_demux_stream_router.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_router.sv
// Registered 1:N stream de-multiplexer with per-channel valid/ready skid registers,
// broadcast mode, and a sticky/saturating record of out-of-range selects.
module demux_stream_router #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CHANNELS = 32,
   parameter int SEL_WIDTH    = $clog2(NUM_CHANNELS),
   parameter int CNT_WIDTH    = 8
) (
   input  logic                               Clock_In,
   input  logic                               Reset_n_In,
   input  logic                               Enable_In,
   input  logic                               Broadcast_In,
   input  logic                               Valid_In,
   output logic                               Ready_Out,
   input  logic [DATA_WIDTH-1:0]              Data_In,
   input  logic [SEL_WIDTH-1:0]               Select_In,
   output logic [NUM_CHANNELS-1:0]            Valid_Out,
   input  logic [NUM_CHANNELS-1:0]            Ready_In,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_Out,
   input  logic                               Clear_Error_In,
   output logic                               Select_Error_Out,
   output logic [CNT_WIDTH-1:0]               Drop_Count_Out
);

   localparam int                 SEL_SPAN = 1 << SEL_WIDTH;
   localparam logic [SEL_WIDTH:0] CH_LIMIT = (SEL_WIDTH+1)'(NUM_CHANNELS);

   logic [NUM_CHANNELS-1:0]            full_q;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_q;
   logic [NUM_CHANNELS-1:0]            can_take;
   logic [NUM_CHANNELS-1:0]            load;
   logic [SEL_SPAN-1:0]                can_take_pad;
   logic                               sel_in_range;
   logic                               ready_c;
   logic                               accept;
   logic                               drop;
   logic                               select_error_q;
   logic [CNT_WIDTH-1:0]               drop_count_q;

   assign can_take     = ~full_q | Ready_In;
   // Padding to the full select span keeps the indexed read in range for any select value.
   assign can_take_pad = SEL_SPAN'(can_take);
   assign sel_in_range = {1'b0, Select_In} < CH_LIMIT;

   always_comb begin
      ready_c = 1'b0;
      if (!Reset_n_In || !Enable_In) begin
         ready_c = 1'b0;
      end else if (Broadcast_In) begin
         ready_c = &can_take;
      end else if (sel_in_range) begin
         ready_c = can_take_pad[Select_In];
      end else begin
         ready_c = 1'b1;
      end
   end

   assign accept = Valid_In & ready_c;
   assign drop   = accept & ~Broadcast_In & ~sel_in_range;

   always_comb begin
      load = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         load[k] = accept & (Broadcast_In | (sel_in_range & (Select_In == SEL_WIDTH'(k))));
      end
   end

   // A load takes priority over a pop so a channel can stream one word per cycle.
   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         full_q <= '0;
         data_q <= '0;
      end else begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (load[k]) begin
               data_q[k*DATA_WIDTH +: DATA_WIDTH] <= Data_In;
               full_q[k]                          <= 1'b1;
            end else if (full_q[k] && Ready_In[k]) begin
               full_q[k] <= 1'b0;
            end
         end
      end
   end

   // A drop on the same edge as a clear restarts the record at one.
   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         select_error_q <= 1'b0;
         drop_count_q   <= '0;
      end else if (drop) begin
         select_error_q <= 1'b1;
         if (Clear_Error_In) begin
            drop_count_q <= CNT_WIDTH'(1);
         end else if (!(&drop_count_q)) begin
            drop_count_q <= drop_count_q + CNT_WIDTH'(1);
         end
      end else if (Clear_Error_In) begin
         select_error_q <= 1'b0;
         drop_count_q   <= '0;
      end
   end

   assign Ready_Out        = ready_c;
   assign Valid_Out        = full_q;
   assign Data_Out         = data_q;
   assign Select_Error_Out = select_error_q;
   assign Drop_Count_Out   = drop_count_q;

endmodule

// File: tb/tb_demux_stream_router.sv
// Scoreboard bench: a 32-channel router under directed and random traffic, plus a
// 20-channel router with a 2-bit drop counter for out-of-range select handling.
module tb_demux_stream_router;

   localparam int DW  = 8;
   localparam int NA  = 32;
   localparam int SWA = 5;
   localparam int NB  = 20;
   localparam int SWB = 5;
   localparam int CWB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic              a_en, a_bc, a_vin, a_clr, a_rout, a_err;
   logic [DW-1:0]     a_din;
   logic [SWA-1:0]    a_sel;
   logic [NA-1:0]     a_rin, a_vout;
   logic [NA*DW-1:0]  a_dout;
   logic [7:0]        a_cnt;

   logic              b_en, b_bc, b_vin, b_clr, b_rout, b_err;
   logic [DW-1:0]     b_din;
   logic [SWB-1:0]    b_sel;
   logic [NB-1:0]     b_rin, b_vout;
   logic [NB*DW-1:0]  b_dout;
   logic [CWB-1:0]    b_cnt;

   demux_stream_router #(.DATA_WIDTH(DW), .NUM_CHANNELS(NA), .CNT_WIDTH(8)) dut_a (
      .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(a_en), .Broadcast_In(a_bc),
      .Valid_In(a_vin), .Ready_Out(a_rout), .Data_In(a_din), .Select_In(a_sel),
      .Valid_Out(a_vout), .Ready_In(a_rin), .Data_Out(a_dout), .Clear_Error_In(a_clr),
      .Select_Error_Out(a_err), .Drop_Count_Out(a_cnt));

   demux_stream_router #(.DATA_WIDTH(DW), .NUM_CHANNELS(NB), .CNT_WIDTH(CWB)) dut_b (
      .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(b_en), .Broadcast_In(b_bc),
      .Valid_In(b_vin), .Ready_Out(b_rout), .Data_In(b_din), .Select_In(b_sel),
      .Valid_Out(b_vout), .Ready_In(b_rin), .Data_Out(b_dout), .Clear_Error_In(b_clr),
      .Select_Error_Out(b_err), .Drop_Count_Out(b_cnt));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected words per channel of router A, oldest first.
   logic [DW-1:0] q [NA][$];
   bit            acc_pend;
   logic [NA-1:0] acc_mask;
   logic [DW-1:0] acc_data;
   logic [NA-1:0] mon_ev;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         mon_ev = '0;
         for (int k = 0; k < NA; k++) mon_ev[k] = (q[k].size() != 0);
         check("a_valid", a_vout, mon_ev);
         for (int k = 0; k < NA; k++) begin
            if (q[k].size() != 0) begin
               if (a_vout[k]) check($sformatf("a_data_ch%0d", k), a_dout[k*DW +: DW], q[k][0]);
               if (a_rin[k]) void'(q[k].pop_front());
            end
         end
      end
   end

   task automatic drive_a(input bit en, input bit bc, input bit v, input logic [DW-1:0] d,
                          input logic [SWA-1:0] s, input logic [NA-1:0] rin);
      bit exp_r;
      bit all_ok;
      @(posedge clk);
      #1;
      if (acc_pend) begin
         for (int k = 0; k < NA; k++) if (acc_mask[k]) q[k].push_back(acc_data);
         acc_pend = 0;
      end
      a_en = en; a_bc = bc; a_vin = v; a_din = d; a_sel = s; a_rin = rin;
      #1;
      all_ok = 1;
      for (int k = 0; k < NA; k++) if (q[k].size() != 0 && !rin[k]) all_ok = 0;
      if (!en)      exp_r = 0;
      else if (bc)  exp_r = all_ok;
      else          exp_r = (q[s].size() == 0) || rin[s];
      check("a_ready", a_rout, exp_r);
      if (v && exp_r) begin
         acc_pend = 1;
         acc_mask = bc ? '1 : (NA'(1) << s);
         acc_data = d;
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3;
      rst_n = 0;
      #1;
      check("rst_a_valid", a_vout, 0);
      check("rst_a_ready", a_rout, 0);
      check("rst_a_data_zero", a_dout == '0, 1);
      check("rst_b_valid", b_vout, 0);
      for (int k = 0; k < NA; k++) q[k].delete();
      acc_pend = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1;
   endtask

   bit            b_err_m;
   logic [CWB-1:0] b_cnt_m;

   task automatic step_b(input bit v, input logic [SWB-1:0] s, input bit clr);
      logic [DW-1:0] d;
      bit            in_range;
      logic [NB-1:0] exp_v;
      d = DW'($urandom);
      in_range = (s < NB);
      @(posedge clk);
      #1;
      b_vin = v; b_sel = s; b_din = d; b_clr = clr;
      #1;
      check("b_ready", b_rout, 1);
      if (v && !in_range) begin
         b_err_m = 1;
         b_cnt_m = clr ? CWB'(1) : ((b_cnt_m == '1) ? b_cnt_m : b_cnt_m + 1'b1);
      end else if (clr) begin
         b_err_m = 0;
         b_cnt_m = '0;
      end
      exp_v = (v && in_range) ? (NB'(1) << s) : '0;
      @(posedge clk);
      #1;
      check("b_error", b_err, b_err_m);
      check("b_count", b_cnt, b_cnt_m);
      check("b_valid", b_vout, exp_v);
      if (v && in_range) check("b_data", b_dout[s*DW +: DW], d);
      b_vin = 0;
      b_clr = 0;
   endtask

   initial begin
      rst_n = 0;
      a_en = 1; a_bc = 0; a_vin = 0; a_din = '0; a_sel = '0; a_rin = '1; a_clr = 0;
      b_en = 1; b_bc = 0; b_vin = 0; b_din = '0; b_sel = '0; b_rin = '1; b_clr = 0;
      acc_pend = 0; b_err_m = 0; b_cnt_m = '0;
      repeat (3) @(posedge clk);
      #2;
      check("init_a_valid", a_vout, 0);
      check("init_a_ready", a_rout, 0);
      check("init_a_data_zero", a_dout == '0, 1);
      check("init_a_err", a_err, 0);
      check("init_a_cnt", a_cnt, 0);
      check("init_b_err", b_err, 0);
      check("init_b_cnt", b_cnt, 0);
      #1;
      rst_n = 1;

      // Unicast to channel 5
      drive_a(1, 0, 1, 8'hA5, 5, '1);
      drive_a(1, 0, 0, 8'h00, 0, '1);
      check("t1_valid", a_vout, 32'h0000_0020);
      check("t1_data", a_dout[5*DW +: DW], 8'hA5);
      drive_a(1, 0, 0, 8'h00, 0, '1);
      check("t1_cleared", a_vout, 0);

      // Backpressure on channel 3
      drive_a(1, 0, 1, 8'h11, 3, ~(NA'(1) << 3));
      drive_a(1, 0, 1, 8'h22, 3, ~(NA'(1) << 3));
      check("t2_stall", a_rout, 0);
      drive_a(1, 0, 1, 8'h22, 3, ~(NA'(1) << 3));
      drive_a(1, 0, 1, 8'h22, 3, '1);
      check("t2_flow", a_rout, 1);
      drive_a(1, 0, 0, 8'h00, 0, '1);
      check("t2_data", a_dout[3*DW +: DW], 8'h22);

      // Broadcast blocked by a full, stalled channel 7
      drive_a(1, 0, 1, 8'h55, 7, ~(NA'(1) << 7));
      drive_a(1, 1, 1, 8'h3C, 0, ~(NA'(1) << 7));
      check("t3_block", a_rout, 0);
      drive_a(1, 1, 1, 8'h3C, 0, ~(NA'(1) << 7));
      drive_a(1, 1, 1, 8'h3C, 0, '1);
      drive_a(1, 0, 0, 8'h00, 0, '1);
      check("t3_all_valid", a_vout, 32'hFFFF_FFFF);
      check("t3_ch31", a_dout[31*DW +: DW], 8'h3C);

      // Enable low stalls input
      drive_a(0, 0, 1, 8'h99, 2, '1);
      check("en_low", a_rout, 0);

      // Reset with channels 0 and 9 holding words
      drive_a(1, 0, 1, 8'h01, 0, '0);
      drive_a(1, 0, 1, 8'h09, 9, '0);
      drive_a(1, 0, 0, 8'h00, 0, '0);
      pulse_reset();
      drive_a(1, 0, 1, 8'h77, 9, '1);
      drive_a(1, 0, 0, 8'h00, 0, '1);
      check("t6_after_rst", a_dout[9*DW +: DW], 8'h77);

      for (int i = 0; i < 1500; i++) begin
         logic [NA-1:0] rin;
         rin = NA'($urandom) | NA'($urandom);
         drive_a(($urandom % 8) != 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                 DW'($urandom), SWA'($urandom), rin);
      end
      drive_a(1, 0, 0, 8'h00, 0, '1);
      drive_a(1, 0, 0, 8'h00, 0, '1);
      drive_a(1, 0, 0, 8'h00, 0, '1);

      // Router B: out-of-range selects on a 20-channel instance
      repeat (3) step_b(1, 25, 0);
      check("t4_err", b_err, 1);
      check("t4_cnt3", b_cnt, 3);
      step_b(1, 25, 1);
      step_b(0, 0, 1);
      step_b(1, 19, 0);
      step_b(1, 20, 0);
      step_b(0, 0, 1);
      repeat (6) step_b(1, 31, 0);
      check("t5_sat", b_cnt, 3);
      for (int i = 0; i < 40; i++) begin
         step_b($urandom % 2, SWB'($urandom_range(0, 31)), ($urandom % 6) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
